// File: rtl/arbitro_tx_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbitro_tx_pkg                                                     |
// | State encoding and requester IDs for the UART transmit arbiter.    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package arbitro_tx_pkg;

  typedef enum logic [2:0] {
    LIBRE     = 3'd0,
    CARGA     = 3'd1,
    ARRANQUE  = 3'd2,
    ENVIANDO  = 3'd3,
    SIGUIENTE = 3'd4,
    FIN_PAQ   = 3'd5
  } estado_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/arbitro_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | arbitro_tx                                                         |
// | Round-robin, packet-granular sharing of one UART transmitter       |
// | between the CPU and the DMA.                                       |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module arbitro_tx
  import arbitro_tx_pkg::*;
#(
  parameter int ESPERA_MAX = 16,
  parameter int ANCHO_TO   = 5
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       cpu_valido,
  input  logic [7:0] cpu_dato,
  input  logic       cpu_ultimo,
  output logic       cpu_ack,
  input  logic       dma_valido,
  input  logic [7:0] dma_dato,
  input  logic       dma_ultimo,
  output logic       dma_ack,
  output logic       tx_inicio,
  output logic [7:0] tx_dato,
  input  logic       tx_listo,
  output logic       ocupado,
  output logic       propietario,
  output logic       error_to
);

  localparam logic [ANCHO_TO-1:0] c_to_ult = ANCHO_TO'(ESPERA_MAX - 1);

  estado_t             r_estado, w_estado;
  logic [ANCHO_TO-1:0] r_cnt, w_cnt;
  logic [7:0]          r_dato, w_dato;
  logic                r_ultimo, w_ultimo;
  logic                r_prop, w_prop;
  logic                r_ocupado, w_ocupado;
  logic                r_error, w_error;
  logic                r_inicio, w_inicio;
  logic                r_cpu_ack, w_cpu_ack;
  logic                r_dma_ack, w_dma_ack;

  logic                w_gana;
  logic                w_own_valido;
  logic [7:0]          w_own_dato;
  logic                w_own_ultimo;

  // On a tie the requester that did not own the last packet wins.
  assign w_gana       = (cpu_valido && dma_valido) ? ~r_prop :
                        (dma_valido ? REQ_DMA : REQ_CPU);
  assign w_own_valido = (r_prop == REQ_DMA) ? dma_valido : cpu_valido;
  assign w_own_dato   = (r_prop == REQ_DMA) ? dma_dato   : cpu_dato;
  assign w_own_ultimo = (r_prop == REQ_DMA) ? dma_ultimo : cpu_ultimo;

  always_comb begin
    w_estado  = r_estado;
    w_cnt     = r_cnt;
    w_dato    = r_dato;
    w_ultimo  = r_ultimo;
    w_prop    = r_prop;
    w_ocupado = r_ocupado;
    w_error   = r_error;
    w_inicio  = 1'b0;
    w_cpu_ack = 1'b0;
    w_dma_ack = 1'b0;
    case (r_estado)
      LIBRE: begin
        if (cpu_valido || dma_valido) begin
          w_prop    = w_gana;
          w_ocupado = 1'b1;
          w_estado  = CARGA;
        end
      end
      CARGA: begin
        if (tx_listo) begin
          w_dato    = w_own_dato;
          w_ultimo  = w_own_ultimo;
          w_inicio  = 1'b1;
          w_cpu_ack = (r_prop == REQ_CPU);
          w_dma_ack = (r_prop == REQ_DMA);
          w_cnt     = '0;
          w_estado  = ARRANQUE;
        end
      end
      ARRANQUE: begin
        if (!tx_listo) begin
          w_cnt    = '0;
          w_estado = ENVIANDO;
        end else if (r_cnt == c_to_ult) begin
          // Transmitter never answered: abandon the rest of the packet.
          w_cnt     = '0;
          w_error   = 1'b1;
          w_ocupado = 1'b0;
          w_estado  = FIN_PAQ;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      ENVIANDO: begin
        if (tx_listo) begin
          if (r_ultimo) begin
            w_ocupado = 1'b0;
            w_estado  = FIN_PAQ;
          end else begin
            w_estado = SIGUIENTE;
          end
        end
      end
      SIGUIENTE: begin
        if (w_own_valido) w_estado = CARGA;
      end
      FIN_PAQ: w_estado = LIBRE;
      default: w_estado = LIBRE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_estado  <= LIBRE;
      r_cnt     <= '0;
      r_dato    <= 8'h00;
      r_ultimo  <= 1'b0;
      r_prop    <= REQ_DMA;
      r_ocupado <= 1'b0;
      r_error   <= 1'b0;
      r_inicio  <= 1'b0;
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
    end else begin
      r_estado  <= w_estado;
      r_cnt     <= w_cnt;
      r_dato    <= w_dato;
      r_ultimo  <= w_ultimo;
      r_prop    <= w_prop;
      r_ocupado <= w_ocupado;
      r_error   <= w_error;
      r_inicio  <= w_inicio;
      r_cpu_ack <= w_cpu_ack;
      r_dma_ack <= w_dma_ack;
    end
  end

  assign cpu_ack     = r_cpu_ack;
  assign dma_ack     = r_dma_ack;
  assign tx_inicio   = r_inicio;
  assign tx_dato     = r_dato;
  assign ocupado     = r_ocupado;
  assign propietario = r_prop;
  assign error_to    = r_error;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_tx.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_arbitro_tx                                                      |
// | Randomized self-checking bench with a packet-level reference model.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_arbitro_tx;

  logic       clk = 1'b0;
  logic       rstn = 1'b1;
  logic       cpu_valido = 1'b0, cpu_ultimo = 1'b0, dma_valido = 1'b0, dma_ultimo = 1'b0;
  logic [7:0] cpu_dato = 8'h00, dma_dato = 8'h00;
  logic       cpu_ack, dma_ack, tx_inicio, tx_listo, ocupado, propietario, error_to;
  logic [7:0] tx_dato;

  arbitro_tx #(.ESPERA_MAX(16), .ANCHO_TO(5)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_valido(cpu_valido), .cpu_dato(cpu_dato), .cpu_ultimo(cpu_ultimo), .cpu_ack(cpu_ack),
    .dma_valido(dma_valido), .dma_dato(dma_dato), .dma_ultimo(dma_ultimo), .dma_ack(dma_ack),
    .tx_inicio(tx_inicio), .tx_dato(tx_dato), .tx_listo(tx_listo),
    .ocupado(ocupado), .propietario(propietario), .error_to(error_to)
  );

  initial forever #5 clk = ~clk;

  typedef struct packed {logic ult; logic [7:0] dato;} ent_t;
  typedef struct packed {logic prop; logic [7:0] dato;} exp_t;
  typedef struct {logic prop; logic [7:0] dato; logic ca; logic da; int cyc;} obs_t;

  ent_t cpu_q[$], dma_q[$], mc[$], md[$];
  exp_t esperado[$];
  obs_t obs[$];
  int   n_tests = 0, n_fail = 0, viol = 0, ciclo = 0;
  int   tx_dur = 4, tx_cnt = 0;
  bit   tx_muerto = 1'b0, tx_forzar = 1'b0;
  logic tx_ready = 1'b1;
  logic m_prop = 1'b1;
  logic p_ini = 1'b0, p_ca = 1'b0, p_da = 1'b0;

  assign tx_listo = tx_ready & ~tx_forzar;

  // Monitor, transmitter model and requester drivers, all on the falling edge.
  initial forever begin
    obs_t o;
    @(negedge clk);
    ciclo++;
    if (tx_inicio) begin
      o.prop = propietario; o.dato = tx_dato; o.ca = cpu_ack; o.da = dma_ack; o.cyc = ciclo;
      obs.push_back(o);
    end
    if (cpu_ack && dma_ack) viol++;
    if ((cpu_ack || dma_ack) !== tx_inicio) viol++;
    if ((tx_inicio && p_ini) || (cpu_ack && p_ca) || (dma_ack && p_da)) viol++;
    p_ini = tx_inicio; p_ca = cpu_ack; p_da = dma_ack;
    if (tx_cnt > 0) begin
      tx_cnt--;
      if (tx_cnt == 0) tx_ready = 1'b1;
    end else if (tx_inicio && !tx_muerto) begin
      tx_ready = 1'b0;
      tx_cnt   = tx_dur;
    end
    if (cpu_ack && cpu_q.size() > 0) void'(cpu_q.pop_front());
    if (dma_ack && dma_q.size() > 0) void'(dma_q.pop_front());
    cpu_valido = (cpu_q.size() > 0);
    if (cpu_valido) begin cpu_dato = cpu_q[0].dato; cpu_ultimo = cpu_q[0].ult; end
    dma_valido = (dma_q.size() > 0);
    if (dma_valido) begin dma_dato = dma_q[0].dato; dma_ultimo = dma_q[0].ult; end
  end

  task automatic encolar(input logic req, input logic ult, input logic [7:0] d);
    ent_t e;
    e.ult = ult; e.dato = d;
    if (req) begin dma_q.push_back(e); md.push_back(e); end
    else begin cpu_q.push_back(e); mc.push_back(e); end
  endtask

  // Packet-level round robin: whole packets alternate whenever both have work.
  task automatic modelo();
    logic who;
    ent_t e;
    exp_t x;
    esperado.delete();
    while (mc.size() > 0 || md.size() > 0) begin
      if (mc.size() > 0 && md.size() > 0) who = ~m_prop;
      else who = (md.size() > 0);
      m_prop = who;
      do begin
        if (who) e = md.pop_front(); else e = mc.pop_front();
        x.prop = who; x.dato = e.dato;
        esperado.push_back(x);
      end while (!e.ult);
    end
  endtask

  task automatic drenar(input int lim);
    int i;
    i = 0;
    while ((cpu_q.size() > 0 || dma_q.size() > 0 || ocupado || !tx_ready) && i < lim) begin
      @(negedge clk); #1;
      i++;
    end
    n_tests++;
    if (i >= lim) begin n_fail++; $display("FAIL drain_timeout: waited %0d cycles, limit %0d", i, lim); end
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    n_tests++; if (cpu_ack !== 1'b0) begin n_fail++; $display("FAIL reset_cpu_ack: got %b want 0", cpu_ack); end
    n_tests++; if (dma_ack !== 1'b0) begin n_fail++; $display("FAIL reset_dma_ack: got %b want 0", dma_ack); end
    n_tests++; if (tx_inicio !== 1'b0) begin n_fail++; $display("FAIL reset_tx_inicio: got %b want 0", tx_inicio); end
    n_tests++; if (tx_dato !== 8'h00) begin n_fail++; $display("FAIL reset_tx_dato: got %h want 00", tx_dato); end
    n_tests++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL reset_ocupado: got %b want 0", ocupado); end
    n_tests++; if (propietario !== 1'b1) begin n_fail++; $display("FAIL reset_propietario: got %b want 1", propietario); end
    n_tests++; if (error_to !== 1'b0) begin n_fail++; $display("FAIL reset_error_to: got %b want 0", error_to); end
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    m_prop = 1'b1;
    viol = 0;
  endtask

  task automatic test_cpu_unico();
    int t_ocup, t_ini, t_sube, t_baja;
    logic prev_listo, prev_ocup;
    t_ocup = -1; t_ini = -1; t_sube = -1; t_baja = -1;
    tx_dur = 10;
    obs.delete();
    encolar(1'b0, 1'b1, 8'hA5);
    mc.delete();
    prev_listo = tx_listo; prev_ocup = ocupado;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk); #1;
      if (ocupado && !prev_ocup && t_ocup < 0) t_ocup = i;
      if (tx_inicio && t_ini < 0) t_ini = i;
      if (tx_listo && !prev_listo) t_sube = i;
      if (!ocupado && prev_ocup) t_baja = i;
      prev_listo = tx_listo; prev_ocup = ocupado;
    end
    m_prop = 1'b0;
    n_tests++;
    if (obs.size() != 1) begin n_fail++; $display("FAIL cpu_single_count: got %0d starts want 1", obs.size()); end
    else begin
      n_tests++;
      if (obs[0].dato !== 8'hA5 || obs[0].ca !== 1'b1 || obs[0].da !== 1'b0) begin
        n_fail++; $display("FAIL cpu_single_byte: got dato=%h ca=%b da=%b want A5 1 0", obs[0].dato, obs[0].ca, obs[0].da);
      end
    end
    n_tests++; if (propietario !== 1'b0) begin n_fail++; $display("FAIL cpu_single_owner: got %b want 0", propietario); end
    n_tests++; if (t_ini - t_ocup !== 1) begin n_fail++; $display("FAIL cpu_single_latency: got %0d want 1", t_ini - t_ocup); end
    n_tests++;
    if (t_sube < 0 || t_baja - t_sube < 1 || t_baja - t_sube > 2) begin
      n_fail++; $display("FAIL cpu_single_ocupado_fall: listo rose at %0d ocupado fell at %0d want 1..2 later", t_sube, t_baja);
    end
  endtask

  task automatic test_alternancia();
    @(negedge clk); #2 rstn = 1'b0;
    @(negedge clk); #1 rstn = 1'b1;
    m_prop = 1'b1;
    tx_dur = 3;
    obs.delete();
    encolar(1'b0, 1'b1, 8'h01); encolar(1'b0, 1'b1, 8'h02);
    encolar(1'b1, 1'b1, 8'h81); encolar(1'b1, 1'b1, 8'h82);
    modelo();
    drenar(400);
    n_tests++;
    if (obs.size() != esperado.size()) begin n_fail++; $display("FAIL alt_count: got %0d want %0d", obs.size(), esperado.size()); end
    for (int i = 0; i < esperado.size() && i < obs.size(); i++) begin
      n_tests++;
      if (obs[i].prop !== esperado[i].prop || obs[i].dato !== esperado[i].dato ||
          obs[i].ca !== ~esperado[i].prop || obs[i].da !== esperado[i].prop) begin
        n_fail++; $display("FAIL alt_byte%0d: got owner=%b dato=%h want owner=%b dato=%h", i, obs[i].prop, obs[i].dato, esperado[i].prop, esperado[i].dato);
      end
    end
  endtask

  task automatic test_dma_paquete();
    bit saw_gap;
    int k;
    exp_t x;
    saw_gap = 1'b0;
    tx_dur = 4;
    obs.delete();
    encolar(1'b1, 1'b0, 8'h11); encolar(1'b1, 1'b0, 8'h22); encolar(1'b1, 1'b1, 8'h33);
    k = 0;
    while (!ocupado && k < 10) begin @(negedge clk); #1; k++; end
    encolar(1'b0, 1'b1, 8'h44);
    mc.delete(); md.delete();
    esperado.delete();
    x.prop = 1'b1; x.dato = 8'h11; esperado.push_back(x);
    x.dato = 8'h22; esperado.push_back(x);
    x.dato = 8'h33; esperado.push_back(x);
    x.prop = 1'b0; x.dato = 8'h44; esperado.push_back(x);
    m_prop = 1'b0;
    for (int i = 0; i < 300 && obs.size() < 4; i++) begin
      @(negedge clk); #1;
      if (obs.size() == 3 && !ocupado) saw_gap = 1'b1;
    end
    drenar(200);
    n_tests++;
    if (obs.size() != 4) begin n_fail++; $display("FAIL dma_pkt_count: got %0d want 4", obs.size()); end
    for (int i = 0; i < 4 && i < obs.size(); i++) begin
      n_tests++;
      if (obs[i].prop !== esperado[i].prop || obs[i].dato !== esperado[i].dato) begin
        n_fail++; $display("FAIL dma_pkt_byte%0d: got owner=%b dato=%h want owner=%b dato=%h", i, obs[i].prop, obs[i].dato, esperado[i].prop, esperado[i].dato);
      end
    end
    n_tests++; if (saw_gap !== 1'b1) begin n_fail++; $display("FAIL dma_pkt_gap: got %b want 1", saw_gap); end
  endtask

  task automatic test_aleatorio();
    int np, nb;
    for (int r = 0; r < 4; r++) begin
      tx_dur = $urandom_range(1, 6);
      obs.delete();
      for (int q = 0; q < 2; q++) begin
        np = $urandom_range(0, 3);
        for (int p = 0; p < np; p++) begin
          nb = $urandom_range(1, 3);
          for (int b = 0; b < nb; b++) encolar(q[0], (b == nb - 1), 8'($urandom));
        end
      end
      modelo();
      drenar(2000);
      n_tests++;
      if (obs.size() != esperado.size()) begin n_fail++; $display("FAIL rand%0d_count: got %0d want %0d", r, obs.size(), esperado.size()); end
      for (int i = 0; i < esperado.size() && i < obs.size(); i++) begin
        n_tests++;
        if (obs[i].prop !== esperado[i].prop || obs[i].dato !== esperado[i].dato ||
            obs[i].ca !== ~esperado[i].prop || obs[i].da !== esperado[i].prop) begin
          n_fail++; $display("FAIL rand%0d_byte%0d: got owner=%b dato=%h want owner=%b dato=%h", r, i, obs[i].prop, obs[i].dato, esperado[i].prop, esperado[i].dato);
        end
      end
    end
    n_tests++; if (error_to !== 1'b0) begin n_fail++; $display("FAIL rand_error_to: got %b want 0", error_to); end
  endtask

  task automatic test_timeout();
    int t_ini, t_err;
    t_ini = -1; t_err = -1;
    tx_muerto = 1'b1;
    obs.delete();
    encolar(1'b0, 1'b1, 8'h5A);
    mc.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk); #1;
      if (tx_inicio && t_ini < 0) t_ini = i;
      if (error_to && t_err < 0) t_err = i;
    end
    n_tests++;
    if (t_ini < 0 || t_err - t_ini < 15 || t_err - t_ini > 18) begin
      n_fail++; $display("FAIL timeout_delay: start at %0d error at %0d want 15..18 later", t_ini, t_err);
    end
    n_tests++; if (ocupado !== 1'b0) begin n_fail++; $display("FAIL timeout_ocupado: got %b want 0", ocupado); end
    tx_muerto = 1'b0;
    obs.delete();
    encolar(1'b0, 1'b1, 8'h5B);
    mc.delete();
    m_prop = 1'b0;
    drenar(200);
    n_tests++;
    if (obs.size() != 1 || obs[0].dato !== 8'h5B) begin n_fail++; $display("FAIL timeout_recover: got %0d starts want one byte 5B", obs.size()); end
    n_tests++; if (error_to !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b want 1", error_to); end
  endtask

  task automatic test_reset_medio();
    bit ok;
    ok = 1'b0;
    tx_dur = 8;
    obs.delete();
    encolar(1'b1, 1'b0, 8'h77); encolar(1'b1, 1'b1, 8'h88);
    md.delete();
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); #1;
      if (obs.size() > 0 && !tx_listo) ok = 1'b1;
    end
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL midreset_start: got %b want 1", ok); end
    @(negedge clk); #3 rstn = 1'b0;
    #1;
    n_tests++;
    if (cpu_ack !== 1'b0 || dma_ack !== 1'b0 || tx_inicio !== 1'b0 || tx_dato !== 8'h00 ||
        ocupado !== 1'b0 || propietario !== 1'b1 || error_to !== 1'b0) begin
      n_fail++; $display("FAIL midreset_outputs: got ack=%b%b ini=%b dato=%h ocup=%b prop=%b err=%b want 00 0 00 0 1 0",
                         cpu_ack, dma_ack, tx_inicio, tx_dato, ocupado, propietario, error_to);
    end
    dma_q.delete();
    @(negedge clk); @(negedge clk); #1 rstn = 1'b1;
    m_prop = 1'b1;
    obs.delete();
    encolar(1'b1, 1'b1, 8'hAA); encolar(1'b0, 1'b1, 8'h99);
    modelo();
    drenar(400);
    n_tests++;
    if (obs.size() != 2) begin n_fail++; $display("FAIL midreset_count: got %0d want 2", obs.size()); end
    for (int i = 0; i < 2 && i < obs.size(); i++) begin
      n_tests++;
      if (obs[i].prop !== esperado[i].prop || obs[i].dato !== esperado[i].dato) begin
        n_fail++; $display("FAIL midreset_byte%0d: got owner=%b dato=%h want owner=%b dato=%h", i, obs[i].prop, obs[i].dato, esperado[i].prop, esperado[i].dato);
      end
    end
  endtask

  task automatic test_listo_bajo();
    int n_ack;
    n_ack = 0;
    tx_forzar = 1'b1;
    tx_dur = 3;
    obs.delete();
    encolar(1'b0, 1'b1, 8'hC3);
    mc.delete();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (cpu_ack || dma_ack) n_ack++;
    end
    n_tests++; if (obs.size() != 0) begin n_fail++; $display("FAIL lowready_start: got %0d starts want 0", obs.size()); end
    n_tests++; if (n_ack != 0) begin n_fail++; $display("FAIL lowready_ack: got %0d acks want 0", n_ack); end
    n_tests++; if (ocupado !== 1'b1) begin n_fail++; $display("FAIL lowready_grant: got ocupado=%b want 1", ocupado); end
    tx_forzar = 1'b0;
    m_prop = 1'b0;
    drenar(200);
    n_tests++;
    if (obs.size() != 1 || obs[0].dato !== 8'hC3 || obs[0].ca !== 1'b1) begin
      n_fail++; $display("FAIL lowready_release: got %0d starts want one C3 with cpu_ack", obs.size());
    end
  endtask

  initial begin
    test_reset();
    test_cpu_unico();
    test_alternancia();
    test_dma_paquete();
    test_aleatorio();
    test_timeout();
    test_reset_medio();
    test_listo_bajo();
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL protocol: got %0d pulse violations want 0", viol); end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
